// File: rtl/rc_axil_regbank_pkg.sv
// Shared response codes, FSM state types and strobe helpers for the rc_axil register bank.
package rc_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Helpers work on the widest legal bus; callers zero-extend and truncate.
  localparam int MAX_DW = 64;
  localparam int MAX_SW = MAX_DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [MAX_DW-1:0] strb_mask(input logic [MAX_SW-1:0] strb);
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_SW; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_SW-1:0] strb);
    logic [MAX_DW-1:0] m;
    m = strb_mask(strb);
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/rc_axil_regbank_if.sv
// AXI4-Lite bus bundle used between the fabric master and the rc_axil register bank.
interface rc_axil_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  // Every channel transfers on the clock edge where VALID and READY are both high;
  // VALID never waits on READY, and payload is held stable while VALID is high.
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rc_axil_regbank_wr_fsm.sv
// AW/W capture and B response for the register bank; emits a one-cycle commit with address, data and strobes.
module rc_axil_wr_fsm
  import rc_axil_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_awaddr,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wstrb,
  input  logic            i_wvalid,
  output logic            o_wready,
  output logic [1:0]      o_bresp,
  output logic            o_bvalid,
  input  logic            i_bready,
  output logic            o_commit,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_strb,
  input  logic            i_commit_ok,
  output wr_state_t       o_state
);

  wr_state_t       r_state, w_state_nxt;
  logic            r_live;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic [1:0]      r_bresp;
  logic            w_aw_hs, w_w_hs;

  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs  = i_wvalid & o_wready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= W_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_state_nxt = W_RESP;
        else if (w_aw_hs)      w_state_nxt = W_HAVE_AW;
        else if (w_w_hs)       w_state_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_w_hs)   w_state_nxt = W_RESP;
      W_HAVE_W:  if (w_aw_hs)  w_state_nxt = W_RESP;
      W_RESP:    if (i_bready) w_state_nxt = W_IDLE;
      default:                 w_state_nxt = W_IDLE;
    endcase
  end

  // r_live keeps both readies low while reset is held and for the reset cycle itself.
  always_comb begin
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    o_commit  = 1'b0;
    case (r_state)
      W_IDLE: begin
        o_awready = r_live;
        o_wready  = r_live;
        o_commit  = w_aw_hs & w_w_hs;
      end
      W_HAVE_AW: begin
        o_wready = 1'b1;
        o_commit = w_w_hs;
      end
      W_HAVE_W: begin
        o_awready = 1'b1;
        o_commit  = w_aw_hs;
      end
      W_RESP:  o_bvalid = 1'b1;
      default: o_bvalid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= AXI_RESP_OKAY;
    end else begin
      if (w_aw_hs) r_awaddr <= i_awaddr;
      if (w_w_hs) begin
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end
      if (o_commit) r_bresp <= i_commit_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end

  // The half that arrives in the completing cycle comes straight from the bus.
  assign o_addr  = (r_state == W_HAVE_AW) ? r_awaddr : i_awaddr;
  assign o_data  = (r_state == W_HAVE_W)  ? r_wdata  : i_wdata;
  assign o_strb  = (r_state == W_HAVE_W)  ? r_wstrb  : i_wstrb;
  assign o_bresp = r_bresp;
  assign o_state = r_state;

endmodule

// File: rtl/rc_axil_regbank.sv
// AXI4-Lite register bank: NUM_CTRL RW control words, NUM_STAT RO status words, SLVERR on unmapped.
// Optional sticky event register with interrupt output when RC_AXIL_REGBANK_IRQ_EN is defined.
module rc_axil_regbank
  import rc_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CTRL           = 4,
  parameter int NUM_STAT           = 2
) (
  input  logic                                                 S_AXI_ACLK,
  input  logic                                                 S_AXI_ARESETN,
  rc_axil_if.slave                                             s_axi,
  output logic [NUM_CTRL*C_S_AXI_DATA_WIDTH-1:0]               ctrl_o,
  output logic [NUM_CTRL-1:0]                                  ctrl_wr_pulse_o,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*C_S_AXI_DATA_WIDTH-1:0] stat_i,
`ifdef RC_AXIL_REGBANK_IRQ_EN
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                        evt_i,
  output logic                                                 irq_o,
`endif
  output wr_state_t                                            o_dbg_wr_state,
  output rd_state_t                                            o_dbg_rd_state
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(DW / 8);
  localparam int STICKY_IDX = NUM_CTRL + NUM_STAT;

  logic [DW-1:0]   r_ctrl [NUM_CTRL];
  logic [NUM_CTRL-1:0] r_wr_pulse;
  logic            r_live;
  rd_state_t       r_rstate, w_rstate_nxt;
  logic [DW-1:0]   r_rdata, w_rdata_nxt;
  logic [1:0]      r_rresp, w_rresp_nxt;
  logic            w_commit, w_commit_ok, w_ar_hs;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic [DW/8-1:0] w_wstrb;
  logic [31:0]     w_widx, w_ridx;
  logic            w_unused_ok;

  rc_axil_wr_fsm #(.DW(DW), .AW(AW)) u_wr_fsm (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .i_awaddr    (s_axi.awaddr),
    .i_awvalid   (s_axi.awvalid),
    .o_awready   (s_axi.awready),
    .i_wdata     (s_axi.wdata),
    .i_wstrb     (s_axi.wstrb),
    .i_wvalid    (s_axi.wvalid),
    .o_wready    (s_axi.wready),
    .o_bresp     (s_axi.bresp),
    .o_bvalid    (s_axi.bvalid),
    .i_bready    (s_axi.bready),
    .o_commit    (w_commit),
    .o_addr      (w_waddr),
    .o_data      (w_wdata),
    .o_strb      (w_wstrb),
    .i_commit_ok (w_commit_ok),
    .o_state     (o_dbg_wr_state)
  );

  assign w_widx = 32'(w_waddr[AW-1:LSB]);
  assign w_ridx = 32'(s_axi.araddr[AW-1:LSB]);

  // Control registers take the commit on the edge that enters W_RESP, together with the pulse.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < NUM_CTRL; k++) r_ctrl[k] <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (w_commit && w_widx == 32'(k)) begin
          r_ctrl[k]     <= DW'(strb_merge(MAX_DW'(r_ctrl[k]), MAX_DW'(w_wdata), MAX_SW'(w_wstrb)));
          r_wr_pulse[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign ctrl_o[g*DW +: DW] = r_ctrl[g];
  end
  assign ctrl_wr_pulse_o = r_wr_pulse;

`ifdef RC_AXIL_REGBANK_IRQ_EN
  logic [DW-1:0] r_sticky, w_clr;
  logic          r_irq;

  assign w_commit_ok = (w_widx < 32'(NUM_CTRL)) || (w_widx == 32'(STICKY_IDX));

  always_comb begin
    w_clr = '0;
    if (w_commit && w_widx == 32'(STICKY_IDX))
      w_clr = w_wdata & DW'(strb_mask(MAX_SW'(w_wstrb)));
  end

  // New events are OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_sticky <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sticky <= (r_sticky & ~w_clr) | evt_i;
      r_irq    <= |(r_sticky & r_ctrl[0]);
    end
  end
  assign irq_o = r_irq;
`else
  assign w_commit_ok = (w_widx < 32'(NUM_CTRL));
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_live   <= 1'b1;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)       w_rstate_nxt = R_DATA;
      R_DATA:  if (s_axi.rready)  w_rstate_nxt = R_IDLE;
      default:                    w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = r_live && (r_rstate == R_IDLE);
    s_axi.rvalid  = (r_rstate == R_DATA);
  end
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;

  // Read mux sees registers before any same-cycle commit lands.
  always_comb begin
    w_rdata_nxt = '0;
    w_rresp_nxt = AXI_RESP_SLVERR;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (w_ridx == 32'(k)) begin
        w_rdata_nxt = r_ctrl[k];
        w_rresp_nxt = AXI_RESP_OKAY;
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (w_ridx == 32'(NUM_CTRL + k)) begin
        w_rdata_nxt = stat_i[k*DW +: DW];
        w_rresp_nxt = AXI_RESP_OKAY;
      end
    end
`ifdef RC_AXIL_REGBANK_IRQ_EN
    if (w_ridx == 32'(STICKY_IDX)) begin
      w_rdata_nxt = r_sticky;
      w_rresp_nxt = AXI_RESP_OKAY;
    end
`endif
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_rdata <= '0;
      r_rresp <= AXI_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rresp_nxt;
    end
  end

  assign s_axi.rdata    = r_rdata;
  assign s_axi.rresp    = r_rresp;
  assign o_dbg_rd_state = r_rstate;

  assign w_unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[LSB-1:0], w_waddr[LSB-1:0], stat_i};

endmodule

// File: tb/tb_rc_axil_regbank.sv
// Bench for rc_axil_regbank: vector table, randomized traffic against a register-map model, hand-built corner sequences.
module tb_rc_axil_regbank;
  import rc_axil_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NC = 4;
  localparam int NS = 2;
  localparam int NV = 20;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rc_axil_if #(.DW(DW), .AW(AW)) axi ();
  logic [NC*DW-1:0] ctrl;
  logic [NC-1:0]    pulse;
  logic [NS*DW-1:0] stat;
  wr_state_t        dbg_w;
  rd_state_t        dbg_r;
`ifdef RC_AXIL_REGBANK_IRQ_EN
  logic [DW-1:0]    evt;
  logic             irq;
`endif

  rc_axil_regbank #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_CTRL(NC), .NUM_STAT(NS)
  ) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rstn),
    .s_axi           (axi),
    .ctrl_o          (ctrl),
    .ctrl_wr_pulse_o (pulse),
    .stat_i          (stat),
`ifdef RC_AXIL_REGBANK_IRQ_EN
    .evt_i           (evt),
    .irq_o           (irq),
`endif
    .o_dbg_wr_state  (dbg_w),
    .o_dbg_rd_state  (dbg_r)
  );

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [33:0] exp_q[$];
  logic [31:0] m_ctrl [NC];
  int          m_pulse [NC] = '{default: 0};
  int          pulse_cnt [NC] = '{default: 0};
  vec_t        vec [NV];

  always @(negedge clk)
    if (rstn) for (int k = 0; k < NC; k++) if (pulse[k]) pulse_cnt[k]++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=handshake", name);
  endtask

  function automatic vec_t mk(input bit wr, input logic [5:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_data = exp_data; v.exp_resp = exp_resp;
    return v;
  endfunction

  // Register map model: a byte-granular write into the addressed word when it is a control word.
  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
    if (idx < NC) begin
      for (int b = 0; b < 4; b++) if (strb[b]) m_ctrl[idx][b*8 +: 8] = data[b*8 +: 8];
      m_pulse[idx]++;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  function automatic logic [33:0] model_read(input int idx);
    if (idx < NC)      return {2'b00, m_ctrl[idx]};
    if (idx < NC + NS) return {2'b00, stat[(idx - NC)*32 +: 32]};
    return {2'b10, 32'h0};
  endfunction

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int n = 0;
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      aw_now = axi.awvalid && axi.awready;
      w_now  = axi.wvalid && axi.wready;
      @(posedge clk); #1;
      if (aw_now) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_now)  begin w_done = 1;  axi.wvalid = 1'b0; end
      n++;
    end
    if (!(aw_done && w_done)) timeout_fail("wr_addr_data");
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
    if (!axi.bvalid) timeout_fail("wr_bvalid");
    resp = axi.bresp;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_now = 0;
    int n = 0;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    while (!ar_now && n < 20) begin
      @(negedge clk);
      ar_now = axi.arready;
      @(posedge clk); #1;
      n++;
    end
    axi.arvalid = 1'b0;
    if (!ar_now) timeout_fail("rd_addr");
    n = 0;
    @(negedge clk);
    while (!axi.rvalid && n < 20) begin @(negedge clk); n++; end
    if (!axi.rvalid) timeout_fail("rd_rvalid");
    data = axi.rdata;
    resp = axi.rresp;
    @(posedge clk); #1;
  endtask

  task automatic sb_check(input string name, input logic [33:0] act);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      timeout_fail({name, "_empty_queue"});
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs, mr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          idx;

    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    stat = {32'hCAFEF00D, 32'hDEADBEEF};
`ifdef RC_AXIL_REGBANK_IRQ_EN
    evt = '0;
`endif
    for (int k = 0; k < NC; k++) m_ctrl[k] = '0;

    vec[0]  = mk(1, 6'h00, 32'h1,        4'hf, 32'h0,        2'b00);
    vec[1]  = mk(1, 6'h04, 32'h2,        4'hf, 32'h0,        2'b00);
    vec[2]  = mk(1, 6'h08, 32'h3,        4'hf, 32'h0,        2'b00);
    vec[3]  = mk(1, 6'h0C, 32'h4,        4'hf, 32'h0,        2'b00);
    vec[4]  = mk(0, 6'h00, 32'h0,        4'h0, 32'h1,        2'b00);
    vec[5]  = mk(0, 6'h04, 32'h0,        4'h0, 32'h2,        2'b00);
    vec[6]  = mk(0, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00);
    vec[7]  = mk(0, 6'h0C, 32'h0,        4'h0, 32'h4,        2'b00);
    vec[8]  = mk(1, 6'h00, 32'hAABBCCDD, 4'hf, 32'h0,        2'b00);
    vec[9]  = mk(1, 6'h00, 32'h11223344, 4'h5, 32'h0,        2'b00);
    vec[10] = mk(0, 6'h00, 32'h0,        4'h0, 32'hAA22CC44, 2'b00);
    vec[11] = mk(1, 6'h10, 32'h12345678, 4'hf, 32'h0,        2'b10);
    vec[12] = mk(1, 6'h3C, 32'h9,        4'hf, 32'h0,        2'b10);
    vec[13] = mk(0, 6'h3C, 32'h0,        4'h0, 32'h0,        2'b10);
    vec[14] = mk(0, 6'h10, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00);
    vec[15] = mk(0, 6'h14, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00);
    vec[16] = mk(0, 6'h02, 32'h0,        4'h0, 32'hAA22CC44, 2'b00);
    vec[17] = mk(0, 6'h0F, 32'h0,        4'h0, 32'h4,        2'b00);
    vec[18] = mk(1, 6'h14, 32'h0,        4'hf, 32'h0,        2'b10);
    vec[19] = mk(0, 6'h20, 32'h0,        4'h0, 32'h0,        2'b10);

    // Reset state, then first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", axi.awready, 0);
    check("rst_wready",  axi.wready,  0);
    check("rst_arready", axi.arready, 0);
    check("rst_bvalid",  axi.bvalid,  0);
    check("rst_rvalid",  axi.rvalid,  0);
    check("rst_rdata",   axi.rdata,   0);
    check("rst_ctrl",    ctrl,        0);
    check("rst_pulse",   pulse,       0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_awready", axi.awready, 1);
    check("post_rst_wready",  axi.wready,  1);
    check("post_rst_arready", axi.arready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vec[i].wr) begin
        model_write(int'(vec[i].addr[5:2]), vec[i].data, vec[i].strb, mr);
        do_write(vec[i].addr, vec[i].data, vec[i].strb, rs);
        check($sformatf("tbl%0d_bresp", i), rs, vec[i].exp_resp);
      end else begin
        do_read(vec[i].addr, rd, rs);
        check($sformatf("tbl%0d_read", i), {rs, rd}, {vec[i].exp_resp, vec[i].exp_data});
      end
    end
    for (int k = 0; k < NC; k++) check($sformatf("tbl_ctrl%0d", k), ctrl[k*32 +: 32], m_ctrl[k]);

    // Randomized traffic against the model through the scoreboard
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
`ifdef RC_AXIL_REGBANK_IRQ_EN
      if (idx == NC + NS) idx = NC + NS + 1;
`endif
      addr = 6'(idx * 4 + $urandom_range(0, 3));
      stat = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        model_write(idx, data, strb, mr);
        exp_q.push_back({mr, 32'h0});
        do_write(addr, data, strb, rs);
        sb_check("rnd_bresp", {rs, 32'h0});
      end else begin
        exp_q.push_back(model_read(idx));
        do_read(addr, rd, rs);
        sb_check("rnd_read", {rs, rd});
      end
    end
    for (int k = 0; k < NC; k++) check($sformatf("rnd_ctrl%0d", k), ctrl[k*32 +: 32], m_ctrl[k]);

    // W arrives three cycles before AW
    axi.wdata = 32'h5A5A5A5A; axi.wstrb = 4'hf; axi.wvalid = 1'b1; axi.bready = 1'b1;
    @(negedge clk);
    check("wfirst_wready", axi.wready, 1);
    @(posedge clk); #1;
    axi.wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wfirst_wready_low", axi.wready,  0);
      check("wfirst_awready",    axi.awready, 1);
      check("wfirst_no_bvalid",  axi.bvalid,  0);
      @(posedge clk); #1;
    end
    axi.awaddr = 6'h04; axi.awvalid = 1'b1;
    @(negedge clk);
    check("wfirst_aw_ready", axi.awready, 1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    @(negedge clk);
    check("wfirst_bvalid", axi.bvalid, 1);
    check("wfirst_bresp",  axi.bresp,  0);
    check("wfirst_ctrl1",  ctrl[32 +: 32], 32'h5A5A5A5A);
    check("wfirst_pulse",  pulse, 4'b0010);
    @(posedge clk); #1;
    m_ctrl[1] = 32'h5A5A5A5A;
    m_pulse[1]++;
    @(negedge clk);
    check("wfirst_bvalid_done", axi.bvalid, 0);
    @(posedge clk); #1;
    for (int k = 0; k < NC; k++) check($sformatf("pulse_cnt%0d", k), pulse_cnt[k], m_pulse[k]);

    // B channel backpressure
    axi.bready = 1'b0;
    axi.awaddr = 6'h08; axi.awvalid = 1'b1;
    axi.wdata = 32'h77; axi.wstrb = 4'hf; axi.wvalid = 1'b1;
    @(negedge clk);
    check("bp_wr_ready", {axi.awready, axi.wready}, 2'b11);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_bvalid",  axi.bvalid, 1);
      check("bp_bresp",   axi.bresp,  0);
      check("bp_readies", {axi.awready, axi.wready}, 2'b00);
      @(posedge clk); #1;
    end
    axi.bready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_bvalid_drop", axi.bvalid, 0);
    @(posedge clk); #1;
    m_ctrl[2] = 32'h77;

    // R channel backpressure, then reset while RVALID is pending
    axi.rready = 1'b0;
    axi.araddr = 6'h08; axi.arvalid = 1'b1;
    @(negedge clk);
    check("bp_arready", axi.arready, 1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rvalid",   axi.rvalid,  1);
      check("bp_rdata",    {axi.rresp, axi.rdata}, {2'b00, m_ctrl[2]});
      check("bp_arready0", axi.arready, 0);
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_rvalid", axi.rvalid, 0);
    check("mid_rst_ctrl",   ctrl, 0);
    check("mid_rst_ready",  {axi.awready, axi.wready, axi.arready}, 3'b000);
    @(posedge clk); #1;
    rstn = 1'b1;
    axi.rready = 1'b1;
    for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rerst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
    @(posedge clk); #1;
    do_read(6'h08, rd, rs);
    check("rerst_read", {rs, rd}, {2'b00, 32'h0});

`ifdef RC_AXIL_REGBANK_IRQ_EN
    do_write(6'h00, 32'h8, 4'hf, rs);
    check("irq_mask_bresp", rs, 0);
    evt = 32'h8;
    @(posedge clk); #1;
    evt = '0;
    idx = 0;
    @(negedge clk);
    while (!irq && idx < 4) begin @(negedge clk); idx++; end
    check("irq_set", irq, 1);
    @(posedge clk); #1;
    do_write(6'h18, 32'h8, 4'hf, rs);
    check("irq_clr_bresp", rs, 0);
    idx = 0;
    @(negedge clk);
    while (irq && idx < 4) begin @(negedge clk); idx++; end
    check("irq_clr", irq, 0);
    @(posedge clk); #1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc_axil_regbank.md
Name: rc_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank for the rate-converter IP family.
- Supersedes the fixed 4-register slave interface.
- Provides NUM_CTRL read/write control registers, driven out as a flat vector, and NUM_STAT read-only status registers, sampled from fabric.
- Adds byte strobes, per-register write pulses and SLVERR decoding for unmapped addresses.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; must cover (NUM_CTRL+NUM_STAT) words.
- NUM_CTRL, 4: number of RW control registers, 1..16.
- NUM_STAT, 2: number of RO status registers, 0..16.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte enables
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
- ctrl_o  out  NUM_CTRL*DW  control registers; reg k at [k*DW +: DW]
- ctrl_wr_pulse_o  out  NUM_CTRL  1-cycle pulse when reg k is written
- stat_i  in  max(NUM_STAT,1)*DW  status words; word k at [k*DW +: DW]

Behaviour:
- Clocking and reset: one clock, S_AXI_ACLK; reset is synchronous and active-low on S_AXI_ARESETN.
- Reset values: all READY/VALID = 0, BRESP/RRESP = 0, RDATA = 0, ctrl_o = 0, pulses = 0. The first cycle after release, AWREADY = WREADY = ARREADY = 1.
- Decode: word index = ADDR[C_S_AXI_ADDR_WIDTH-1 : log2(DW/8)]; low byte bits are ignored.
  - idx < NUM_CTRL: control register.
  - idx < NUM_CTRL+NUM_STAT: status register.
  - otherwise: unmapped.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW and W both handshake in the same cycle -> W_RESP.
    - AW only -> W_HAVE_AW (AWREADY drops, WREADY stays 1).
    - W only -> W_HAVE_W (WREADY drops, AWREADY stays 1).
  - W_HAVE_AW: on W handshake -> W_RESP. W_HAVE_W: on AW handshake -> W_RESP.
  - On entry to W_RESP (the cycle after the completing handshake), the commit is applied:
    - Control idx: bytes with WSTRB=1 are updated, BRESP=OKAY, ctrl_wr_pulse_o[idx]=1 for exactly this cycle.
    - Status idx: no update, BRESP=SLVERR.
    - Unmapped: no update, BRESP=SLVERR.
    - BVALID=1 in the same cycle.
  - W_RESP: both readies = 0. BVALID holds until BREADY, then -> W_IDLE with readies = 1 on the next cycle.
  - Throughput: at most one write per 2 cycles with BREADY tied high.
- Read FSM, states R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1):
  - On AR handshake in cycle t: RDATA/RRESP are registered and RVALID=1 in cycle t+1.
    - Control idx: current register value, OKAY.
    - Status idx: stat_i word sampled at cycle t, OKAY.
    - Unmapped: RDATA=0, SLVERR.
  - RDATA/RRESP stay stable while RVALID=1 and RREADY=0. On R handshake -> R_IDLE.
- Read and write channels are independent. A read of a register being committed in the same cycle returns the pre-commit value.
- Reset asserted mid-transaction: both FSMs return to idle, in-flight transactions are dropped, ctrl_o clears.

Optional Feature:
- Macro: RC_AXIL_REGBANK_IRQ_EN.
- When defined:
  - Adds input evt_i[DW-1:0] and output irq_o.
  - Adds a sticky register at idx NUM_CTRL+NUM_STAT:
    - bit b is set on evt_i[b]=1.
    - write-1-to-clear with WSTRB; a set in the same cycle as a clear wins.
    - reads OKAY.
  - irq_o = OR of the sticky bits AND control register 0's mask, registered (1-cycle latency). irq_o resets to 0.
- When undefined: that address is unmapped (SLVERR) and the ports are absent.

Decomposition:
- Package rc_axil_pkg:
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - wr_state_t and rd_state_t enums.
  - Function for strobe-merge of a DW word.
- One sub-module, rc_axil_wr_fsm: AW/W capture and B response, outputting commit strobe, idx and data. The read path and register array stay in the top.

Test Plan:
- Basic write/readback: write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC -> reads return the same values, all RRESP/BRESP=OKAY, ctrl_o words match, one pulse per write.
- Partial strobe: reg0=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44.
- W before AW: WVALID 3 cycles ahead of AWVALID to addr 0x4, data 0x5A5A5A5A -> WREADY drops after its handshake, reg1=0x5A5A5A5A, BVALID exactly 1 cycle after the AW handshake.
- Error paths: write to a status addr and to an unmapped addr 0x3C -> BRESP=SLVERR and ctrl_o unchanged; read 0x3C -> RDATA=0, RRESP=SLVERR; read status 0 with stat_i word0=0xDEADBEEF -> 0xDEADBEEF, OKAY.
- Backpressure and reset: hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID/RDATA stable, no new AW/AR accepted; pull ARESETN low during RVALID -> next cycle RVALID=0, ctrl_o=0.
- Under RC_AXIL_REGBANK_IRQ_EN: pulse evt_i bit 3 with mask reg0=0x8 -> irq_o=1 after 1 cycle; write 0x8 to the sticky reg -> irq_o=0.
